// File: rtl/ds3_pkg.sv
// Shared constants for the DS3 G.752 receive framing path.
// Widths of the position counters and the alignment word live here.
package ds3_pkg;
  localparam int SR_W    = 25;
  localparam int WORD_W  = 7;
  localparam int BLK_LEN = 680;
  localparam int NSUB    = 7;
  localparam int A_W     = 10;
  localparam int L_W     = 3;
  localparam int K_W     = 8;
  localparam logic [7:0] FAW = 8'b0011_0011;
  localparam logic [K_W-1:0] K_MAX = '1;
endpackage

// File: rtl/clk_div_n.sv
// Free-running divide-by-N strobe; high for the last N/2 counts
// of each period (1 of 3 for N=3, 2 of 4 for N=4).
module clk_div_n #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic reset,
  output logic div
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (cnt == CW'(N - 1))
      cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      div <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      div <= (cnt_nxt >= CW'(N - N / 2));
    end
  end
endmodule

// File: rtl/ds3_frame_locator.sv
// DS3 serial front end: bit shifter, 7-bit word demux, alignment
// word hunt with sticky lock, position counters and divided clocks.
module ds3_frame_locator
  import ds3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [WORD_W-1:0] out,
  output logic              q,
  output logic              clk2,
  output logic              clk3,
  output logic              clk4,
  output logic [A_W-1:0]    a,
  output logic [L_W-1:0]    l,
  output logic [K_W-1:0]    k,
  output logic [A_W-1:0]    b
);
  logic [SR_W-1:0] sr;
  logic [2:0]      wc;
  logic            m;
  logic            unused_sr;

  // Match includes the bit arriving on this edge.
  assign m = ({sr[6:0], in} == FAW);
  assign unused_sr = ^sr[SR_W-1:7];

  always_ff @(posedge clk) begin
    if (reset)
      sr <= '0;
    else
      sr <= {sr[SR_W-2:0], in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wc  <= '0;
      out <= '0;
    end else if (wc == 3'd6) begin
      wc  <= '0;
      out <= {sr[WORD_W-2:0], in};
    end else begin
      wc  <= wc + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      l <= '0;
    end else if (a == A_W'(BLK_LEN - 1)) begin
      a <= '0;
      if (l == L_W'(NSUB - 1))
        l <= '0;
      else
        l <= l + L_W'(1);
    end else begin
      a <= a + A_W'(1);
    end
  end

  // b latches the frame address once; later hits only bump k.
  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
      q <= 1'b0;
      b <= '0;
    end else if (m) begin
      if (k != K_MAX)
        k <= k + K_W'(1);
      if (!q) begin
        q <= 1'b1;
        b <= a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      clk2 <= 1'b0;
    else
      clk2 <= ~clk2;
  end

  clk_div_n #(.N(3)) u_div3 (
    .clk  (clk),
    .reset(reset),
    .div  (clk3)
  );

  clk_div_n #(.N(4)) u_div4 (
    .clk  (clk),
    .reset(reset),
    .div  (clk4)
  );
endmodule

// File: tb/tb_ds3_frame_locator.sv
// Bench for ds3_frame_locator: directed scenarios plus random
// line data, checked against an edge-count/bit-history model.
module tb_ds3_frame_locator;
  logic       clk = 1'b0;
  logic       reset_s = 1'b1;
  logic       in_s = 1'b0;
  logic [6:0] out;
  logic       q, clk2, clk3, clk4;
  logic [9:0] a, b;
  logic [2:0] l;
  logic [7:0] k;

  int vecs = 0;
  int errs = 0;

  ds3_frame_locator dut (
    .clk  (clk),
    .reset(reset_s),
    .in   (in_s),
    .out  (out),
    .q    (q),
    .clk2 (clk2),
    .clk3 (clk3),
    .clk4 (clk4),
    .a    (a),
    .l    (l),
    .k    (k),
    .b    (b)
  );

  always #5 clk = ~clk;

  // Model: edges since reset plus the recent bit history.
  int         n = 0;
  bit         hist[$];
  int         m_k = 0;
  bit         m_q = 0;
  int         m_b = 0;
  int         m_out = 0;
  logic [6:0] e_out;
  logic       e_q, e_c2, e_c3, e_c4;
  logic [9:0] e_a, e_b;
  logic [2:0] e_l;
  logic [7:0] e_k;

  function automatic int lastbits(input int w);
    int v = 0;
    for (int i = 0; i < w; i++) begin
      int idx = hist.size() - w + i;
      v = (v << 1) | ((idx >= 0) ? int'(hist[idx]) : 0);
    end
    return v;
  endfunction

  task automatic model(input bit bv, input bit rv);
    if (rv) begin
      n = 0;
      hist.delete();
      m_k = 0; m_q = 0; m_b = 0; m_out = 0;
    end else begin
      hist.push_back(bv);
      if (lastbits(8) == 'h33) begin
        if (m_k < 255) m_k++;
        if (!m_q) begin
          m_q = 1;
          m_b = n % 680;
        end
      end
      if (n % 7 == 6) m_out = lastbits(7);
      n++;
      if (hist.size() > 8) void'(hist.pop_front());
    end
    e_out = 7'(m_out);
    e_q   = m_q;
    e_b   = 10'(m_b);
    e_k   = 8'(m_k);
    e_a   = 10'(n % 680);
    e_l   = 3'((n / 680) % 7);
    e_c2  = (n % 2) == 1;
    e_c3  = (n % 3) == 2;
    e_c4  = (n % 4) >= 2;
  endtask

  task automatic tick(input bit bv, input bit rv);
    in_s = bv;
    reset_s = rv;
    @(posedge clk);
    model(bv, rv);
    #1;
  endtask

  task automatic feed_faw();
    logic [7:0] p = 8'b0011_0011;
    for (int i = 7; i >= 0; i--) tick(p[i], 0);
  endtask

  task automatic test_reset();
    bit c2s[4] = '{1, 0, 1, 0};
    bit c3s[4] = '{0, 1, 0, 0};
    bit c4s[4] = '{0, 1, 1, 0};
    tick(0, 1);
    tick(0, 1);
    vecs++;
    if ({out, q, clk2, clk3, clk4, a, l, k, b} !== '0) begin
      errs++;
      $display("FAIL reset_zero: got out=%h q=%b c=%b%b%b a=%0d l=%0d k=%0d b=%0d, want all 0",
               out, q, clk2, clk3, clk4, a, l, k, b);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0);
      vecs++;
      if ({clk2, clk3, clk4} !== {c2s[i], c3s[i], c4s[i]}) begin
        errs++;
        $display("FAIL div_pattern[%0d]: got %b%b%b want %b%b%b",
                 i, clk2, clk3, clk4, c2s[i], c3s[i], c4s[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] p = 8'b0011_0011;
    tick(0, 1);
    for (int i = 0; i < 25; i++) tick(1, 0);
    for (int i = 7; i >= 1; i--) tick(p[i], 0);
    vecs++;
    if (q !== 1'b0) begin
      errs++;
      $display("FAIL lock_early: q=%b want 0", q);
    end
    tick(p[0], 0);
    vecs++;
    if ({q, b, k} !== {1'b1, 10'd32, 8'd1}) begin
      errs++;
      $display("FAIL lock: q=%b b=%0d k=%0d want q=1 b=32 k=1", q, b, k);
    end
  endtask

  task automatic test_periodic();
    for (int g = 0; g < 20; g++) begin
      tick(0, 0); tick(0, 0); tick(1, 0); tick(1, 0);
      vecs++;
      if ({q, b, k} !== {1'b1, 10'd32, 8'(2 + g)}) begin
        errs++;
        $display("FAIL periodic[%0d]: q=%b b=%0d k=%0d want 1 32 %0d",
                 g, q, b, k, 2 + g);
      end
    end
    for (int g = 0; g < 240; g++) begin
      tick(0, 0); tick(0, 0); tick(1, 0); tick(1, 0);
    end
    vecs++;
    if (k !== 8'd255) begin
      errs++;
      $display("FAIL k_sat: k=%0d want 255", k);
    end
    for (int g = 0; g < 8; g++) begin
      tick(0, 0); tick(0, 0); tick(1, 0); tick(1, 0);
    end
    vecs++;
    if ({q, b, k} !== {1'b1, 10'd32, 8'd255}) begin
      errs++;
      $display("FAIL k_hold: q=%b b=%0d k=%0d want 1 32 255", q, b, k);
    end
  endtask

  task automatic test_wrap();
    tick(0, 1);
    for (int i = 0; i < 679; i++) tick(0, 0);
    vecs++;
    if ({a, l} !== {10'd679, 3'd0}) begin
      errs++;
      $display("FAIL a_pre_wrap: a=%0d l=%0d want 679 0", a, l);
    end
    tick(0, 0);
    vecs++;
    if ({a, l} !== {10'd0, 3'd1}) begin
      errs++;
      $display("FAIL a_wrap: a=%0d l=%0d want 0 1", a, l);
    end
    for (int i = 0; i < 6 * 680 - 1; i++) tick(0, 0);
    vecs++;
    if ({a, l} !== {10'd679, 3'd6}) begin
      errs++;
      $display("FAIL l_pre_wrap: a=%0d l=%0d want 679 6", a, l);
    end
    tick(0, 0);
    vecs++;
    if ({a, l} !== {10'd0, 3'd0}) begin
      errs++;
      $display("FAIL l_wrap: a=%0d l=%0d want 0 0", a, l);
    end
  endtask

  task automatic test_word();
    logic [6:0] w = 7'b1011001;
    tick(0, 1);
    for (int i = 6; i >= 1; i--) tick(w[i], 0);
    vecs++;
    if (out !== 7'd0) begin
      errs++;
      $display("FAIL word_early: out=%b want 0000000", out);
    end
    tick(w[0], 0);
    vecs++;
    if (out !== 7'b1011001) begin
      errs++;
      $display("FAIL word: out=%b want 1011001", out);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom_range(0, 1)), 0);
      vecs++;
      if (out !== 7'b1011001) begin
        errs++;
        $display("FAIL word_hold[%0d]: out=%b want 1011001", i, out);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] p = 8'b0011_0011;
    tick(0, 1);
    feed_faw();
    for (int i = 0; i < 13; i++) tick(0, 0);
    vecs++;
    if ({q, b} !== {1'b1, 10'd7}) begin
      errs++;
      $display("FAIL relock_pre: q=%b b=%0d want 1 7", q, b);
    end
    for (int i = 7; i >= 1; i--) tick(p[i], 0);
    tick(p[0], 1);
    vecs++;
    if ({q, b, k, a, l} !== '0) begin
      errs++;
      $display("FAIL midrun_reset: q=%b b=%0d k=%0d a=%0d l=%0d want all 0",
               q, b, k, a, l);
    end
    tick(0, 0); tick(0, 0); tick(0, 0);
    feed_faw();
    vecs++;
    if ({q, b, k} !== {1'b1, 10'd10, 8'd1}) begin
      errs++;
      $display("FAIL relock: q=%b b=%0d k=%0d want 1 10 1", q, b, k);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      logic [3:0] nib = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0011;
      for (int j = 3; j >= 0; j--) begin
        tick(nib[j], $urandom_range(0, 499) == 0);
        vecs++;
        if ({out, q, clk2, clk3, clk4, a, l, k, b} !==
            {e_out, e_q, e_c2, e_c3, e_c4, e_a, e_l, e_k, e_b}) begin
          errs++;
          $display("FAIL random[%0d]: out=%h q=%b c=%b%b%b a=%0d l=%0d k=%0d b=%0d want out=%h q=%b c=%b%b%b a=%0d l=%0d k=%0d b=%0d",
                   i, out, q, clk2, clk3, clk4, a, l, k, b,
                   e_out, e_q, e_c2, e_c3, e_c4, e_a, e_l, e_k, e_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_periodic();
    test_wrap();
    test_word();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
